mul4_seq: RTL and testbench

- Sequential unsigned shift-add multiplier built downstream of the 4-bit adder stage.
- Consumes the same operand pair (inA, inB) and reuses one WIDTH-bit add with carry-out per cycle to form a 2*WIDTH-bit product over WIDTH cycles.
- Start/busy/done handshake; result held until the next operation completes.
- Sits between the operand source and the result/display logic of the arithmetic datapath.

---
 rtl/mul4_seq.sv | 84 ++++++++
 tb/tb_mul4_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mul4_seq.sv
// Sequential unsigned shift-add multiplier: one WIDTH-bit add with carry per cycle,
// producing a 2*WIDTH-bit product after WIDTH iterations with a start/busy/done handshake.
module mul4_seq #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH-1:0]       inA,
    input  logic [WIDTH-1:0]       inB,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH-1:0]     product,
    output logic                   zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   m_reg;
    logic [2*WIDTH-1:0] p_reg;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] p_next;

    // The carry-out lands in the MSB of the shifted accumulator, so no bit is ever lost.
    always_comb begin
        sum    = {1'b0, p_reg[2*WIDTH-1:WIDTH]};
        if (p_reg[0]) begin
            sum = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + {1'b0, m_reg};
        end
        p_next = {sum, p_reg[WIDTH-1:1]};
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            m_reg   <= '0;
            p_reg   <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            zero    <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_reg <= inA;
                        p_reg <= {{WIDTH{1'b0}}, inB};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    p_reg <= p_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        product <= p_next;
                        zero    <= (p_next == '0);
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul4_seq.sv
// Directed self-checking bench for mul4_seq: handshake timing, back-to-back,
// start-during-calc, asynchronous abort and an exhaustive product sweep.
module tb_mul4_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] inA;
    logic [3:0] inB;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic       zero;

    int tests = 0;
    int fails = 0;

    mul4_seq #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .inA     (inA),
        .inB     (inB),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zero    (zero)
    );

    always #5 clk = ~clk;

    // Issue one operation and follow it (sampling on falling edges) until done or timeout.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                         output int busy_cnt, output bit got_done, output logic [7:0] prod);
        @(negedge clk);
        start = 1'b1; inA = a; inB = b;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0; got_done = 1'b0; prod = 'x;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got_done = 1'b1;
                prod = product;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; inA = '0; inB = '0;
        #1 rst_n = 1'b0;
        #2;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b want=0", done); end
        tests++; if (product !== 8'h00) begin fails++; $display("FAIL reset_product got=%h want=00", product); end
        tests++; if (zero !== 1'b1) begin fails++; $display("FAIL reset_zero got=%b want=1", zero); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_max();
        int bc; bit gd; logic [7:0] p;
        do_op(4'hF, 4'hF, bc, gd, p);
        tests++; if (bc !== 4) begin fails++; $display("FAIL max_busy_cycles got=%0d want=4", bc); end
        tests++; if (gd !== 1'b1) begin fails++; $display("FAIL max_done got=%b want=1", gd); end
        tests++; if (p !== 8'hE1) begin fails++; $display("FAIL max_product got=%h want=e1", p); end
        tests++; if (zero !== 1'b0) begin fails++; $display("FAIL max_zero got=%b want=0", zero); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL max_busy_with_done got=%b want=0", busy); end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL max_done_pulse got=%b want=0", done); end
        tests++; if (product !== 8'hE1) begin fails++; $display("FAIL max_hold got=%h want=e1", product); end
    endtask

    task automatic test_patterns();
        int bc; bit gd; logic [7:0] p;
        do_op(4'h9, 4'h6, bc, gd, p);
        tests++; if (p !== 8'h36) begin fails++; $display("FAIL mul_9x6 got=%h want=36", p); end
        tests++; if (zero !== 1'b0) begin fails++; $display("FAIL zero_9x6 got=%b want=0", zero); end
        do_op(4'h0, 4'hB, bc, gd, p);
        tests++; if (p !== 8'h00) begin fails++; $display("FAIL mul_0xb got=%h want=00", p); end
        tests++; if (zero !== 1'b1) begin fails++; $display("FAIL zero_0xb got=%b want=1", zero); end
        repeat (3) @(negedge clk);
        tests++; if (zero !== 1'b1 || product !== 8'h00) begin
            fails++; $display("FAIL idle_hold got=%h/%b want=00/1", product, zero);
        end
    endtask

    task automatic test_start_ignored();
        int pulses = 0;
        logic [7:0] p = 'x;
        @(negedge clk); start = 1'b1; inA = 4'h3; inB = 4'h5;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; inA = 4'hF; inB = 4'hF;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin pulses++; p = product; end
            tests++; if (busy && done) begin fails++; $display("FAIL busy_and_done cycle=%0d", i); end
            @(negedge clk);
        end
        tests++; if (pulses !== 1) begin fails++; $display("FAIL ignored_pulses got=%0d want=1", pulses); end
        tests++; if (p !== 8'h0F) begin fails++; $display("FAIL ignored_product got=%h want=0f", p); end
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        bit seen = 1'b0;
        @(negedge clk); start = 1'b1; inA = 4'h2; inB = 4'h7;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        tests++; if (!seen) begin fails++; $display("FAIL b2b_first_timeout got=no_done want=done"); end
        tests++; if (product !== 8'h0E) begin fails++; $display("FAIL b2b_first got=%h want=0e", product); end
        inA = 4'h4; inB = 4'h4;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else begin
                tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_gap cycle=%0d busy=%b want=1", cyc, busy); end
                tests++; if (product !== 8'h0E) begin fails++; $display("FAIL b2b_hold got=%h want=0e", product); end
            end
        end
        start = 1'b0;
        tests++; if (cyc !== 5) begin fails++; $display("FAIL b2b_spacing got=%0d want=5", cyc); end
        tests++; if (product !== 8'h10) begin fails++; $display("FAIL b2b_second got=%h want=10", product); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bc; bit gd; logic [7:0] p;
        int pulses = 0;
        @(negedge clk); start = 1'b1; inA = 4'hF; inB = 4'hF;
        @(negedge clk); start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b want=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_done got=%b want=0", done); end
        tests++; if (product !== 8'h00) begin fails++; $display("FAIL abort_product got=%h want=00", product); end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL abort_activity got=%0d want=0", pulses); end
        do_op(4'h7, 4'h9, bc, gd, p);
        tests++; if (p !== 8'h3F) begin fails++; $display("FAIL after_abort got=%h want=3f", p); end
    endtask

    task automatic test_exhaustive();
        int bc; bit gd; logic [7:0] p; logic [7:0] exp;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                exp = 8'(a * b);
                do_op(4'(a), 4'(b), bc, gd, p);
                tests++;
                if (!gd || p !== exp) begin
                    fails++;
                    $display("FAIL exhaustive %0d*%0d NG got=%h done=%b want=%h", a, b, p, gd, exp);
                end else begin
                    $display("exhaustive %0d*%0d OK", a, b);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_patterns();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
